// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned INSTR_W     = 16;
    localparam int unsigned OPCODE_HI   = 15;
    localparam int unsigned OPCODE_LO   = 12;
    localparam logic [3:0]  HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2,
        HALTED  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the instruction RAM address, captures the returned word
// one cycle later and offers it to decode with a valid/ready handshake.
// Branch redirects override everything except the halted state.
module instr_fetch_unit #(
    parameter int unsigned        ADDR_W      = fetch_pkg::ADDR_W,
    parameter int unsigned        INSTR_W     = fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter logic [3:0]         HALT_OPCODE = fetch_pkg::HALT_OPCODE
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  iram_addr,
    input  logic [INSTR_W-1:0] iram_q,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               halted
);

    import fetch_pkg::*;

    fetch_state_e       state, state_d;
    logic [ADDR_W-1:0]  pc, pc_d;
    logic [INSTR_W-1:0] ir_d;
    logic [ADDR_W-1:0]  ir_pc_d;
    logic               ir_valid_d;
    logic               halted_d;
    logic               handshake;
    logic               is_halt;

    // The RAM address is the pc register itself, never a bypass of branch_target.
    assign iram_addr = pc;
    assign handshake = ir_valid & ir_ready;
    assign is_halt   = (ir[OPCODE_HI:OPCODE_LO] == HALT_OPCODE);

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ISSUE;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            ir       <= ir_d;
            ir_pc    <= ir_pc_d;
            ir_valid <= ir_valid_d;
            halted   <= halted_d;
        end
    end

    // Next-state and datapath update; a branch wins over capture and halt detection.
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        ir_d       = ir;
        ir_pc_d    = ir_pc;
        ir_valid_d = ir_valid;
        halted_d   = halted;

        if (state != HALTED && branch_valid) begin
            pc_d       = branch_target;
            ir_valid_d = 1'b0;
            state_d    = ISSUE;
        end else begin
            case (state)
                ISSUE: begin
                    if (fetch_en) begin
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    ir_d       = iram_q;
                    ir_pc_d    = pc;
                    ir_valid_d = 1'b1;
                    pc_d       = pc + ADDR_W'(1);
                    state_d    = HOLD;
                end
                HOLD: begin
                    if (handshake) begin
                        ir_valid_d = 1'b0;
                        if (is_halt) begin
                            halted_d = 1'b1;
                            state_d  = HALTED;
                        end else begin
                            state_d  = ISSUE;
                        end
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = ISSUE;
                end
            endcase
        end
    end

endmodule
